// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipelined control and hazard unit for the 5-stage MIPS core
//
// Decodes the ID-stage instruction into combinational NPC/extender selects,
// carries registered control bundles through EX, MEM and WB, and raises the
// stall that freezes PC and IF/ID on load-use and branch-operand hazards.
//
// Optional feature macro: PIPE_CTRL_MDU_EN (multiply/divide decode, busy
// counter and the ex_mdu_start output).
//
// Ports:
//   clk, reset_n                  clock (rising) / async active-low reset
//   id_instr, id_valid            ID-stage instruction and its valid flag
//   flush                         load a bubble into EX at the next edge
//   ext_stall                     memory-side freeze of EX/MEM/WB
//   stall                         hold PC and IF/ID
//   id_si_ext, id_branch, id_j,
//   id_jr, id_jl                  combinational ID controls
//   ex_alu_op, ex_alu_src2,
//   ex_waddr, ex_we               EX-stage controls
//   mem_waddr, mem_we_reg, mem_we MEM-stage controls
//   wb_waddr, wb_we, wb_sel       WB-stage controls
//   ex_mdu_start                  one-cycle pulse when mult/div enters EX

module pipe_ctrl #(
  parameter int ALUOP_W  = 4,
  parameter int LINK_REG = 31,
  parameter int MDU_LAT  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        id_instr,
  input  logic               id_valid,
  input  logic               flush,
  input  logic               ext_stall,
  output logic               stall,
  output logic               id_si_ext,
  output logic               id_branch,
  output logic               id_j,
  output logic               id_jr,
  output logic               id_jl,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src2,
  output logic [4:0]         ex_waddr,
  output logic               ex_we,
  output logic [4:0]         mem_waddr,
  output logic               mem_we_reg,
  output logic               mem_we,
  output logic [4:0]         wb_waddr,
  output logic               wb_we,
`ifdef PIPE_CTRL_MDU_EN
  output logic               ex_mdu_start,
`endif
  output logic [1:0]         wb_sel
);

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src2;
    logic               mem_we;
    logic               we;
    logic [4:0]         waddr;
    logic [1:0]         sel;
    logic               is_load;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];

  ctrl_t id_dec;
  logic  rs_use, rt_use, is_beq, is_jr, is_j, is_jl, si_ext;
  logic  id_mdu_op;   // mult/multu/div/divu
  logic  id_mfx;      // mfhi/mflo

  always_comb begin
    id_dec    = BUBBLE;
    rs_use    = 1'b0;
    rt_use    = 1'b0;
    is_beq    = 1'b0;
    is_jr     = 1'b0;
    is_j      = 1'b0;
    is_jl     = 1'b0;
    si_ext    = 1'b0;
    id_mdu_op = 1'b0;
    id_mfx    = 1'b0;
    if (id_valid) begin
      case (op)
        6'h00: begin
          case (funct)
            6'h21: begin  // addu
              id_dec.we    = 1'b1;
              id_dec.waddr = rd;
              rs_use       = 1'b1;
              rt_use       = 1'b1;
            end
            6'h23: begin  // subu
              id_dec.alu_op = ALUOP_W'(1);
              id_dec.we     = 1'b1;
              id_dec.waddr  = rd;
              rs_use        = 1'b1;
              rt_use        = 1'b1;
            end
            6'h08: begin  // jr
              is_jr  = 1'b1;
              rs_use = 1'b1;
            end
`ifdef PIPE_CTRL_MDU_EN
            6'h18, 6'h19, 6'h1A, 6'h1B: begin  // mult/multu/div/divu
              id_mdu_op = 1'b1;
              rs_use    = 1'b1;
              rt_use    = 1'b1;
            end
            6'h10, 6'h12: begin  // mfhi/mflo
              id_mfx       = 1'b1;
              id_dec.we    = 1'b1;
              id_dec.waddr = rd;
              id_dec.sel   = 2'd3;
            end
`endif
            default: ;
          endcase
        end
        6'h0D: begin  // ori
          id_dec.alu_op   = ALUOP_W'(3);
          id_dec.alu_src2 = 1'b1;
          id_dec.we       = 1'b1;
          id_dec.waddr    = rt;
          rs_use          = 1'b1;
        end
        6'h23: begin  // lw
          id_dec.alu_src2 = 1'b1;
          id_dec.we       = 1'b1;
          id_dec.waddr    = rt;
          id_dec.sel      = 2'd1;
          id_dec.is_load  = 1'b1;
          si_ext          = 1'b1;
          rs_use          = 1'b1;
        end
        6'h2B: begin  // sw
          id_dec.alu_src2 = 1'b1;
          id_dec.mem_we   = 1'b1;
          si_ext          = 1'b1;
          rs_use          = 1'b1;
          rt_use          = 1'b1;
        end
        6'h0F: begin  // lui
          id_dec.alu_op   = ALUOP_W'(5);
          id_dec.alu_src2 = 1'b1;
          id_dec.we       = 1'b1;
          id_dec.waddr    = rt;
        end
        6'h04: begin  // beq
          is_beq = 1'b1;
          si_ext = 1'b1;
          rs_use = 1'b1;
          rt_use = 1'b1;
        end
        6'h02: is_j = 1'b1;  // j
        6'h03: begin         // jal
          is_j         = 1'b1;
          is_jl        = 1'b1;
          id_dec.we    = 1'b1;
          id_dec.waddr = 5'(LINK_REG);
          id_dec.sel   = 2'd2;
        end
        6'h09: begin  // addiu
          id_dec.alu_src2 = 1'b1;
          id_dec.we       = 1'b1;
          id_dec.waddr    = rt;
          si_ext          = 1'b1;
          rs_use          = 1'b1;
        end
        default: ;
      endcase
    end
    // Writes to $0 are architecturally discarded, so never enable them.
    if (id_dec.waddr == 5'd0) id_dec.we = 1'b0;
  end

  assign id_si_ext = si_ext;
  assign id_branch = is_beq;
  assign id_j      = is_j;
  assign id_jr     = is_jr;
  assign id_jl     = is_jl;

  ctrl_t ex_q, mem_q, wb_q;

  // Hazard detection
  logic ex_match, mem_match, early_use, hazard, mdu_hazard;

  assign ex_match  = (rs_use && rs == ex_q.waddr)  || (rt_use && rt == ex_q.waddr);
  assign mem_match = (rs_use && rs == mem_q.waddr) || (rt_use && rt == mem_q.waddr);
  // beq/jr resolve in ID, so they also need results still sitting in EX/MEM.
  assign early_use = is_beq || is_jr;

`ifdef PIPE_CTRL_MDU_EN
  localparam int CW = $clog2(MDU_LAT + 1);
  logic [CW-1:0] mdu_cnt;
  logic          mdu_start_q;

  assign mdu_hazard   = (mdu_cnt != '0) && (id_mfx || id_mdu_op);
  assign ex_mdu_start = mdu_start_q;
`else
  assign mdu_hazard = 1'b0;
`endif

  assign hazard = (ex_q.is_load && ex_q.waddr != 5'd0 && ex_match)
                || (early_use && ex_q.we && ex_match)
                || (early_use && mem_q.is_load && mem_match)
                || mdu_hazard;

  assign stall = hazard || ext_stall;

  // Stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else if (!ext_stall) begin
      ex_q  <= (hazard || flush) ? BUBBLE : id_dec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

`ifdef PIPE_CTRL_MDU_EN
  // The counter survives flush: the divider keeps running even if the
  // instruction stream around it is squashed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdu_cnt     <= '0;
      mdu_start_q <= 1'b0;
    end else if (ext_stall) begin
      mdu_start_q <= 1'b0;
    end else if (id_mdu_op && !hazard && !flush) begin
      mdu_cnt     <= CW'(MDU_LAT);
      mdu_start_q <= 1'b1;
    end else begin
      mdu_start_q <= 1'b0;
      if (mdu_cnt != '0) mdu_cnt <= mdu_cnt - 1'b1;
    end
  end
`endif

  assign ex_alu_op   = ex_q.alu_op;
  assign ex_alu_src2 = ex_q.alu_src2;
  assign ex_waddr    = ex_q.waddr;
  assign ex_we       = ex_q.we;
  assign mem_waddr   = mem_q.waddr;
  assign mem_we_reg  = mem_q.we;
  assign mem_we      = mem_q.mem_we;
  assign wb_waddr    = wb_q.waddr;
  assign wb_we       = wb_q.we;
  assign wb_sel      = wb_q.sel;

  // Fields carried for completeness but not exported from every stage.
  logic unused_fields;
  assign unused_fields = ^{ex_q.mem_we, ex_q.sel, mem_q.alu_op, mem_q.alu_src2,
                           mem_q.sel, wb_q.alu_op, wb_q.alu_src2, wb_q.mem_we,
                           wb_q.is_load, id_instr[10:6]};

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] id_instr;
  logic        id_valid, flush, ext_stall;
  logic        stall, id_si_ext, id_branch, id_j, id_jr, id_jl;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src2, ex_we, mem_we_reg, mem_we, wb_we;
  logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
  logic [1:0]  wb_sel;
`ifdef PIPE_CTRL_MDU_EN
  logic        ex_mdu_start;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.ALUOP_W(4), .LINK_REG(31), .MDU_LAT(5)) dut (
    .clk(clk), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .flush(flush), .ext_stall(ext_stall), .stall(stall),
    .id_si_ext(id_si_ext), .id_branch(id_branch), .id_j(id_j), .id_jr(id_jr),
    .id_jl(id_jl), .ex_alu_op(ex_alu_op), .ex_alu_src2(ex_alu_src2),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .mem_waddr(mem_waddr),
    .mem_we_reg(mem_we_reg), .mem_we(mem_we), .wb_waddr(wb_waddr),
    .wb_we(wb_we),
`ifdef PIPE_CTRL_MDU_EN
    .ex_mdu_start(ex_mdu_start),
`endif
    .wb_sel(wb_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic issue(input logic [31:0] ins);
    id_instr = ins;
    id_valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    id_instr = 32'd0;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; id_instr = 32'd0; id_valid = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    #12;
    check("rst_ex_we", ex_we, 0);
    check("rst_wb_we", wb_we, 0);
    check("rst_wb_sel", wb_sel, 0);
    check("rst_stall", stall, 0);
    check("rst_ex_waddr", ex_waddr, 0);
    reset_n = 1'b1;
    tick();

    // addu $3,$1,$2 : ID -> WB in 3 edges
    issue(rtype(1, 2, 3, 'h21));
    check("addu_stall_id", stall, 0);
    tick(); idle();
    check("addu_ex_we", ex_we, 1);
    check("addu_ex_waddr", ex_waddr, 3);
    check("addu_ex_aluop", ex_alu_op, 0);
    check("addu_ex_src2", ex_alu_src2, 0);
    check("addu_wb_we_early", wb_we, 0);
    tick();
    check("addu_mem_we_reg", mem_we_reg, 1);
    check("addu_mem_waddr", mem_waddr, 3);
    tick();
    check("addu_wb_we", wb_we, 1);
    check("addu_wb_waddr", wb_waddr, 3);
    check("addu_wb_sel", wb_sel, 0);
    check("addu_stall", stall, 0);
    tick(); tick();

    // lw $5,0($0) then addu $6,$5,$1 : one load-use bubble
    issue(itype('h23, 0, 5, 0));
    check("lw_si_ext", id_si_ext, 1);
    tick();
    check("lw_ex_src2", ex_alu_src2, 1);
    check("lw_ex_waddr", ex_waddr, 5);
    issue(rtype(5, 1, 6, 'h21));
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble", ex_we, 0);
    check("lu_mem_waddr", mem_waddr, 5);
    check("lu_stall_clear", stall, 0);
    tick(); idle();
    check("lu_addu_ex_waddr", ex_waddr, 6);
    check("lu_addu_ex_we", ex_we, 1);
    check("lw_wb_sel", wb_sel, 1);
    check("lw_wb_waddr", wb_waddr, 5);
    check("lw_wb_we", wb_we, 1);
    tick(); tick(); tick();

    // addiu $4,$0,1 in EX, beq $4,$0 in ID
    issue(itype('h09, 0, 4, 1));
    tick();
    issue(itype('h04, 4, 0, 'hfffc));
    check("beq_ex_stall", stall, 1);
    check("beq_branch", id_branch, 1);
    check("beq_si_ext", id_si_ext, 1);
    idle();
    tick(); tick(); tick();

    // lw $4 in EX then MEM with beq $4 in ID
    issue(itype('h23, 0, 4, 8));
    tick();
    issue(itype('h04, 4, 0, 2));
    check("beq_lw_ex_stall", stall, 1);
    tick();
    check("beq_lw_mem_stall", stall, 1);
    check("beq_lw_bubble", ex_we, 0);
    tick();
    check("beq_lw_release", stall, 0);
    idle();
    tick(); tick(); tick();

    // ori $0,$0,1 : no write, no dependants stalled
    issue(itype('h0D, 0, 0, 1));
    check("ori_si_ext", id_si_ext, 0);
    tick();
    check("ori0_ex_we", ex_we, 0);
    check("ori0_ex_aluop", ex_alu_op, 3);
    issue(itype('h04, 0, 0, 1));
    check("ori0_beq_stall", stall, 0);
    issue(rtype(0, 0, 7, 'h21));
    check("ori0_addu_stall", stall, 0);

    // lui / subu / sw decode
    issue(itype('h0F, 0, 2, 'h1234));
    tick();
    check("lui_aluop", ex_alu_op, 5);
    check("lui_src2", ex_alu_src2, 1);
    issue(rtype(8, 9, 10, 'h23));
    tick();
    check("subu_aluop", ex_alu_op, 1);
    check("subu_waddr", ex_waddr, 10);
    issue(itype('h2B, 0, 0, 4));
    tick();
    check("sw_ex_we", ex_we, 0);
    idle();
    tick();
    check("sw_mem_we", mem_we, 1);
    tick(); tick(); tick();

    // jal then jr $31
    issue({6'h03, 26'h0000040});
    check("jal_j", id_j, 1);
    check("jal_jl", id_jl, 1);
    tick(); idle(); tick(); tick();
    check("jal_wb_waddr", wb_waddr, 31);
    check("jal_wb_sel", wb_sel, 2);
    check("jal_wb_we", wb_we, 1);
    issue(rtype(31, 0, 0, 'h08));
    check("jr_jr", id_jr, 1);
    check("jr_jl", id_jl, 0);
    check("jr_stall", stall, 0);
    tick(); idle();
    check("jr_ex_we", ex_we, 0);
    tick(); tick(); tick();

    // ext_stall freeze for 4 cycles
    issue(rtype(1, 2, 3, 'h21)); tick();
    issue(itype('h23, 0, 5, 0)); tick();
    issue(itype('h0D, 1, 9, 7)); tick();
    issue(rtype(1, 2, 8, 'h21));
    ext_stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("xs_ex_waddr", ex_waddr, 9);
      check("xs_mem_waddr", mem_waddr, 5);
      check("xs_wb_waddr", wb_waddr, 3);
      check("xs_stall", stall, 1);
    end
    ext_stall = 1'b0;
    tick();
    check("xs_resume_ex", ex_waddr, 8);
    check("xs_resume_wb", wb_waddr, 5);
    idle(); tick(); tick(); tick();

    // flush together with a hazard: a single bubble
    issue(itype('h23, 0, 5, 0)); tick();
    issue(rtype(5, 1, 6, 'h21));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fh_bubble", ex_we, 0);
    tick();
    check("fh_single_bubble", ex_waddr, 6);
    // flush alone
    issue(rtype(1, 2, 7, 'h21));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_bubble_we", ex_we, 0);
    check("flush_bubble_waddr", ex_waddr, 0);

    // async reset mid-cycle
    issue(rtype(1, 2, 11, 'h21)); tick(); tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ex_we", ex_we, 0);
    check("arst_mem_we_reg", mem_we_reg, 0);
    check("arst_wb_we", wb_we, 0);
    check("arst_wb_waddr", wb_waddr, 0);
    #3;
    reset_n = 1'b1;
    idle();
    tick(); tick();

`ifdef PIPE_CTRL_MDU_EN
    // mult then mfhi: stall for the 5 busy cycles
    issue(rtype(1, 2, 0, 'h18));
    tick();
    check("mdu_start", ex_mdu_start, 1);
    issue(rtype(0, 0, 10, 'h10));
    for (int i = 0; i < 5; i++) begin
      check("mdu_stall", stall, 1);
      tick();
      if (i == 0) check("mdu_start_once", ex_mdu_start, 0);
    end
    check("mdu_stall_end", stall, 0);
    tick(); idle();
    check("mfhi_ex_waddr", ex_waddr, 10);
    tick(); tick();
    check("mfhi_wb_sel", wb_sel, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle instruction decoder for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Decodes the ID-stage instruction and emits combinational ID controls for the NPC and extender.
- Carries registered control bundles through EX, MEM and WB.
- Detects load-use and branch-operand hazards and generates the stall that freezes PC and IF/ID.

Parameters:
- ALUOP_W, 4, ALU operation code width.
- LINK_REG, 31, destination register for jal.
- MDU_LAT, 5, multiply/divide busy cycles (used only with PIPE_CTRL_MDU_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_instr  in  32  instruction in ID.
- id_valid  in  1  id_instr holds a real instruction; 0 means decode as nop.
- flush  in  1  load a bubble into EX at the next edge.
- ext_stall  in  1  memory-side freeze of the whole pipeline.
- stall  out  1  hold PC and IF/ID.
- id_si_ext  out  1  sign-extend (else zero-extend) imm16.
- id_branch, id_j, id_jr, id_jl  out  1 each  NPC selects for beq/j-family.
- ex_alu_op  out  ALUOP_W  ALU operation: addu/addiu/lw/sw=0, subu=1, ori=3, lui=5.
- ex_alu_src2  out  1  ALU B = extended immediate.
- ex_waddr, mem_waddr, wb_waddr  out  5 each  destination register per stage.
- ex_we, mem_we_reg, wb_we  out  1 each  register write enable per stage.
- mem_we  out  1  data-memory write.
- wb_sel  out  2  write-back source: 0 ALU, 1 memory, 2 PC+8.

Behaviour:
- Decode set: addu, subu, jr, ori, lw, sw, lui, beq, j, jal, addiu.
- Any other opcode/funct, or id_valid=0, decodes as nop: all enables 0, waddr 0.
- Destination: rd for addu/subu; rt for ori/lw/lui/addiu; LINK_REG for jal.
- Any instruction whose destination is register 0 carries its write enable forced to 0.
- ID outputs are combinational from id_instr and id_valid.
- Stage registers EX, MEM, WB hold {alu_op, alu_src2, mem_we, we, waddr, sel, is_load}. Each stage advances one step per edge, so ID-to-WB control latency is 3 cycles.
- Operand use: rs is used by addu, subu, jr, ori, lw, sw, addiu, beq. rt is used by addu, subu, sw, beq.
- Hazard stall (combinational), asserted if any of the following holds:
  - EX is_load, ex_waddr≠0, and ex_waddr matches a used source of ID.
  - ID is beq or jr, and ex_we=1 with ex_waddr matching a used source.
  - ID is beq or jr, and MEM is_load with mem_waddr matching a used source.
- stall output = hazard OR ext_stall.
- Update priority at each edge:
  - ext_stall=1: EX, MEM and WB all hold.
  - Otherwise, hazard or flush: EX loads a bubble (all-zero bundle) while MEM←EX and WB←MEM.
  - Otherwise: EX←ID decode.
- flush together with a hazard produces a single bubble, identical to either alone.
- Reset, asynchronous and active-low: every stage register clears to the bubble, so all registered outputs are 0. stall depends only on the cleared registers and inputs.
- Reset asserted mid-operation discards all in-flight controls immediately; there is no partial write-back.

Optional Feature:
- Macro: PIPE_CTRL_MDU_EN.
- When defined, the decoder also accepts:
  - mult, multu, div, divu (funct 0x18, 0x19, 0x1A, 0x1B): rs and rt used, no register write.
  - mfhi, mflo (funct 0x10, 0x12): writes rd, wb_sel=3.
- Extra output ex_mdu_start (1 bit) pulses for one cycle when a mult/div enters EX.
- An internal busy counter loads MDU_LAT on that entry and decrements each un-frozen cycle down to 0.
- While the counter is nonzero:
  - ID mfhi/mflo asserts stall.
  - A new ID mult/div also asserts stall.
- flush does not clear the counter; reset clears it to 0.
- When undefined: those encodings decode as nop, the counter logic is absent, ex_mdu_start is not present, and wb_sel never takes the value 3.

Test Plan:
- Reset then release; drive addu $3,$1,$2 with id_valid=1 → EX: we=1, waddr=3, alu_op=0; WB: wb_we=1, wb_waddr=3 after exactly 3 edges; stall=0 throughout.
- lw $5,0($0) followed by addu $6,$5,$1 → stall=1 for one cycle, EX holds a bubble (ex_we=0) for one cycle, then addu enters EX and stall=0.
- addiu $4,$0,1 in EX while ID holds beq $4,$0 → stall=1. lw $4 in MEM with beq $4 in ID → stall=1. ori $0,$0,1 → ex_we=0 and never stalls a dependant.
- jal in ID → id_j=1, id_jl=1; three edges later wb_waddr=31, wb_sel=2, wb_we=1. jr $31 → id_jr=1, no register write.
- ext_stall held for 4 cycles mid-stream → EX/MEM/WB outputs unchanged across those cycles. flush together with a hazard → exactly one bubble. Async reset_n low between edges → all outputs 0 before the next edge.
- With PIPE_CTRL_MDU_EN and MDU_LAT=5: mult then mfhi back-to-back → ex_mdu_start pulses once, stall held 5 cycles, then mfhi enters EX with wb_sel=3.
